// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan driver and its BCM timer.
package hub75_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      BLANK,
      LATCH,
      DISPLAY
   } state_t;

   localparam int R_LSB  = 8;
   localparam int G_LSB  = 4;
   localparam int B_LSB  = 0;
   localparam int PLANES = 4;

endpackage

// File: rtl/hub75_bcm_timer.sv
// Bit-plane display timer: loads BASE_TIME<<plane, counts down, and owns the oe_n low window.
module hub75_bcm_timer
   import hub75_pkg::*;
#(
   parameter int BASE_TIME = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic [1:0] i_plane,
   output logic       o_oe_n,
   output logic       o_done
);

   localparam int CNT_W = $clog2((BASE_TIME << (PLANES - 1)) + 1);

   logic [CNT_W-1:0] r_count;
   logic             r_active;
   logic             r_oe_n;
   logic [31:0]      w_len;

   assign w_len = 32'(BASE_TIME) << i_plane;

   // oe_n goes low on the cycle after load and stays low for exactly w_len cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_active <= 1'b0;
         r_oe_n   <= 1'b1;
      end else if (i_load) begin
         r_count  <= CNT_W'(w_len - 32'd1);
         r_active <= 1'b1;
         r_oe_n   <= 1'b0;
      end else if (r_active) begin
         if (r_count == '0) begin
            r_active <= 1'b0;
            r_oe_n   <= 1'b1;
         end else begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign o_oe_n = r_oe_n;
   assign o_done = r_active && (r_count == '0);

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 1/32-scan driver: reads pixel pairs from RAM port B and shows them with 4-plane BCM.
//
// state   | meaning
// IDLE    | panel blanked, waiting for en
// SHIFT   | 4-cycle column slots: read upper, read lower, drive colour, pclk high
// BLANK   | one cycle, row_addr moves to the current row
// LATCH   | one cycle lat pulse
// DISPLAY | oe_n low for BASE_TIME<<plane cycles, then next plane / row / frame end
module hub75_scan_driver
   import hub75_pkg::*;
#(
   parameter int WIDTH     = 128,
   parameter int HEIGHT    = 64,
   parameter int BPP       = 12,
   parameter int CHAINED   = 1,
   parameter int BASE_TIME = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   output logic [13:0]                   addr_b,
   output logic                          re_b,
   input  logic [BPP-1:0]                dat_out_b,
   output logic                          r0,
   output logic                          g0,
   output logic                          b0,
   output logic                          r1,
   output logic                          g1,
   output logic                          b1,
   output logic [$clog2(HEIGHT/2)-1:0]   row_addr,
   output logic                          pclk,
   output logic                          lat,
   output logic                          oe_n,
   output logic                          frame_done
);

   localparam int L     = WIDTH * CHAINED;
   localparam int ROWS  = HEIGHT / 2;
   localparam int COL_W = $clog2(L);
   localparam int ROW_W = $clog2(ROWS);

   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(L - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [1:0]       PLANE_LAST = 2'(PLANES - 1);

   function automatic logic [13:0] f_addr(input logic [31:0] row, input logic [31:0] col);
      return 14'(row * 32'(L) + col);
   endfunction

   state_t           r_state;
   logic [1:0]       r_slot;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [1:0]       r_plane;
   logic [BPP-1:0]   r_upper;
   logic [13:0]      r_addr_b;
   logic             r_re_b;
   logic [2:0]       r_rgb0;
   logic [2:0]       r_rgb1;
   logic [ROW_W-1:0] r_row_addr;
   logic             r_pclk;
   logic             r_lat;
   logic             r_frame_done;

   logic [PLANES-1:0] w_up_r, w_up_g, w_up_b;
   logic [PLANES-1:0] w_lo_r, w_lo_g, w_lo_b;
   logic [ROW_W-1:0]  w_next_row;
   logic              w_tmr_load;
   logic              w_tmr_done;
   logic              w_oe_n;

   assign w_up_r = r_upper[R_LSB +: PLANES];
   assign w_up_g = r_upper[G_LSB +: PLANES];
   assign w_up_b = r_upper[B_LSB +: PLANES];
   assign w_lo_r = dat_out_b[R_LSB +: PLANES];
   assign w_lo_g = dat_out_b[G_LSB +: PLANES];
   assign w_lo_b = dat_out_b[B_LSB +: PLANES];

   assign w_next_row = (r_plane == PLANE_LAST) ? r_row + 1'b1 : r_row;
   assign w_tmr_load = (r_state == LATCH);

   hub75_bcm_timer #(
      .BASE_TIME (BASE_TIME)
   ) u_bcm_timer (
      .clk     (clk),
      .rst_n   (rst),
      .i_load  (w_tmr_load),
      .i_plane (r_plane),
      .o_oe_n  (w_oe_n),
      .o_done  (w_tmr_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_slot       <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_plane      <= '0;
         r_upper      <= '0;
         r_addr_b     <= '0;
         r_re_b       <= 1'b0;
         r_rgb0       <= '0;
         r_rgb1       <= '0;
         r_row_addr   <= '0;
         r_pclk       <= 1'b0;
         r_lat        <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_lat        <= 1'b0;
         r_frame_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_re_b <= 1'b0;
               r_pclk <= 1'b0;
               if (en) begin
                  r_state  <= SHIFT;
                  r_slot   <= 2'd0;
                  r_row    <= '0;
                  r_plane  <= '0;
                  r_col    <= COL_LAST;
                  r_addr_b <= f_addr(32'd0, 32'(COL_LAST));
                  r_re_b   <= 1'b1;
               end
            end
            SHIFT: begin
               // RAM data arrives one cycle after each read address is presented.
               unique case (r_slot)
                  2'd0: begin
                     r_addr_b <= f_addr(32'(r_row) + 32'(ROWS), 32'(r_col));
                     r_re_b   <= 1'b1;
                     r_pclk   <= 1'b0;
                     r_slot   <= 2'd1;
                  end
                  2'd1: begin
                     r_upper <= dat_out_b;
                     r_re_b  <= 1'b0;
                     r_slot  <= 2'd2;
                  end
                  2'd2: begin
                     r_rgb0 <= {w_up_r[r_plane], w_up_g[r_plane], w_up_b[r_plane]};
                     r_rgb1 <= {w_lo_r[r_plane], w_lo_g[r_plane], w_lo_b[r_plane]};
                     r_pclk <= 1'b0;
                     r_slot <= 2'd3;
                  end
                  2'd3: begin
                     r_pclk <= 1'b1;
                     r_slot <= 2'd0;
                     if (r_col == '0) begin
                        r_state    <= BLANK;
                        r_row_addr <= r_row;
                     end else begin
                        r_col    <= r_col - 1'b1;
                        r_addr_b <= f_addr(32'(r_row), 32'(r_col) - 32'd1);
                        r_re_b   <= 1'b1;
                     end
                  end
               endcase
            end
            BLANK: begin
               r_pclk  <= 1'b0;
               r_lat   <= 1'b1;
               r_state <= LATCH;
            end
            LATCH: begin
               r_state <= DISPLAY;
            end
            DISPLAY: begin
               if (w_tmr_done) begin
                  r_plane <= r_plane + 1'b1;
                  if (r_plane == PLANE_LAST && r_row == ROW_LAST) begin
                     r_row        <= '0;
                     r_state      <= IDLE;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_row    <= w_next_row;
                     r_state  <= SHIFT;
                     r_slot   <= 2'd0;
                     r_col    <= COL_LAST;
                     r_addr_b <= f_addr(32'(w_next_row), 32'(COL_LAST));
                     r_re_b   <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign addr_b     = r_addr_b;
   assign re_b       = r_re_b;
   assign r0         = r_rgb0[2];
   assign g0         = r_rgb0[1];
   assign b0         = r_rgb0[0];
   assign r1         = r_rgb1[2];
   assign g1         = r_rgb1[1];
   assign b1         = r_rgb1[0];
   assign row_addr   = r_row_addr;
   assign pclk       = r_pclk;
   assign lat        = r_lat;
   assign oe_n       = w_oe_n;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench for hub75_scan_driver: random RAM image, reference frame model, decoupled monitor.
module tb_hub75_scan_driver;

   localparam int WIDTH     = 128;
   localparam int HEIGHT    = 64;
   localparam int CHAINED   = 1;
   localparam int BASE_TIME = 8;
   localparam int L         = WIDTH * CHAINED;
   localparam int ROWS      = HEIGHT / 2;
   localparam int FRAME_CYC = ROWS * (4 * (4 * L + 2) + 15 * BASE_TIME);

   logic        clk = 1'b0;
   logic        rst, en;
   logic [13:0] addr_b;
   logic        re_b;
   logic [11:0] dat_out_b = '0;
   logic        r0, g0, b0, r1, g1, b1;
   logic [4:0]  row_addr;
   logic        pclk, lat, oe_n, frame_done;

   logic        rst2, en2;
   logic [13:0] addr_b2;
   logic        re_b2;
   logic [11:0] dat_out_b2 = '0;
   logic        r0_2, g0_2, b0_2, r1_2, g1_2, b1_2;
   logic [4:0]  row_addr2;
   logic        pclk2, lat2, oe_n2, frame_done2;

   always #5 clk = ~clk;

   hub75_scan_driver #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BPP(12), .CHAINED(CHAINED), .BASE_TIME(BASE_TIME)
   ) u_dut (
      .clk(clk), .rst(rst), .en(en), .addr_b(addr_b), .re_b(re_b), .dat_out_b(dat_out_b),
      .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
      .row_addr(row_addr), .pclk(pclk), .lat(lat), .oe_n(oe_n), .frame_done(frame_done)
   );

   hub75_scan_driver #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BPP(12), .CHAINED(2), .BASE_TIME(BASE_TIME)
   ) u_dut2 (
      .clk(clk), .rst(rst2), .en(en2), .addr_b(addr_b2), .re_b(re_b2), .dat_out_b(dat_out_b2),
      .r0(r0_2), .g0(g0_2), .b0(b0_2), .r1(r1_2), .g1(g1_2), .b1(b1_2),
      .row_addr(row_addr2), .pclk(pclk2), .lat(lat2), .oe_n(oe_n2), .frame_done(frame_done2)
   );

   logic [11:0] mem [0:8191];

   always @(posedge clk) if (re_b)  dat_out_b  <= mem[addr_b[12:0]];
   always @(posedge clk) if (re_b2) dat_out_b2 <= addr_b2[11:0];

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard queues filled by the reference model
   int q_addr[$];
   int q_pix[$];
   int q_win_len[$];
   int q_win_row[$];

   bit mon_on     = 0;
   bit prev_pclk  = 0;
   bit prev_oe_n  = 1;
   bit prev_fd    = 0;
   bit seen_first = 0;
   bit row_moved  = 0;
   int lat_cnt    = 0;
   int run_len    = 0;
   int win_row    = 0;
   int t_first    = 0;
   int t_done     = 0;
   int n_done     = 0;
   int fd_cycles  = 0;

   always @(negedge clk) begin
      if (mon_on) begin
         if (re_b) begin
            if (!seen_first) begin
               seen_first = 1;
               t_first    = cyc;
            end
            if (q_addr.size() == 0) check("addr_extra_read", int'(addr_b), -1);
            else check("addr_b", int'(addr_b), q_addr.pop_front());
         end
         if (pclk && !prev_pclk) begin
            if (q_pix.size() == 0) check("pixel_extra_pclk", 1, 0);
            else check("pixel_rgb", int'({r0, g0, b0, r1, g1, b1}), q_pix.pop_front());
         end
         if (lat) begin
            lat_cnt++;
            check("oe_n_during_lat", int'(oe_n), 1);
         end
         if (!oe_n) begin
            if (prev_oe_n) begin
               check("lat_pulses_before_window", lat_cnt, 1);
               lat_cnt   = 0;
               run_len   = 0;
               win_row   = int'(row_addr);
               row_moved = 0;
            end
            run_len++;
            if (int'(row_addr) != win_row) row_moved = 1;
         end else if (!prev_oe_n) begin
            if (q_win_len.size() == 0) check("window_extra", run_len, 0);
            else begin
               check("window_len", run_len, q_win_len.pop_front());
               check("window_row", win_row, q_win_row.pop_front());
               check("row_stable_in_window", int'(row_moved), 0);
            end
         end
         if (frame_done) begin
            fd_cycles++;
            if (!prev_fd) begin
               n_done++;
               t_done = cyc;
            end
         end
      end
      prev_pclk = pclk;
      prev_oe_n = oe_n;
      prev_fd   = frame_done;
   end

   initial begin
      int k;
      int hold;
      int npclk;
      bit pp;
      int up, lo;
      logic [11:0] pu, pl;

      rst = 0; en = 0; rst2 = 0; en2 = 0;
      for (int i = 0; i < 8192; i++) mem[i] = 12'($urandom);
      mem[127]  = 12'hA5C;
      mem[4223] = 12'h3F0;

      repeat (3) @(negedge clk);
      check("rst_addr_b", int'(addr_b), 0);
      check("rst_re_b", int'(re_b), 0);
      check("rst_rgb0", int'({r0, g0, b0}), 0);
      check("rst_rgb1", int'({r1, g1, b1}), 0);
      check("rst_row_addr", int'(row_addr), 0);
      check("rst_pclk", int'(pclk), 0);
      check("rst_lat", int'(lat), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_oe_n", int'(oe_n), 1);

      // Chained panel: first read address and pclk count for the first plane pass
      rst2 = 1; en2 = 1;
      k = 0;
      while (!re_b2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("chain_first_re", int'(re_b2), 1);
      check("chain_first_addr", int'(addr_b2), 255);
      npclk = 0; pp = 0; k = 0;
      while (k < 3000) begin
         @(negedge clk);
         k++;
         if (lat2) break;
         if (pclk2 && !pp) npclk++;
         pp = pclk2;
      end
      check("chain_pclk_per_pass", npclk, 256);
      rst2 = 0; en2 = 0;

      // Reset asserted partway through the first SHIFT pass
      @(negedge clk);
      rst = 1; en = 1;
      repeat ($urandom_range(8, 500)) @(negedge clk);
      rst = 0;
      #1;
      check("midrst_oe_n", int'(oe_n), 1);
      check("midrst_lat", int'(lat), 0);
      check("midrst_pclk", int'(pclk), 0);
      check("midrst_re_b", int'(re_b), 0);
      check("midrst_addr_b", int'(addr_b), 0);
      en = 0;

      // Reference frame: rows, then planes, then columns high to low
      for (int r = 0; r < ROWS; r++) begin
         for (int p = 0; p < 4; p++) begin
            for (int c = L - 1; c >= 0; c--) begin
               up = r * L + c;
               lo = (r + ROWS) * L + c;
               q_addr.push_back(up);
               q_addr.push_back(lo);
               pu = mem[up];
               pl = mem[lo];
               q_pix.push_back(int'({pu[8+p], pu[4+p], pu[p], pl[8+p], pl[4+p], pl[p]}));
            end
            q_win_len.push_back(BASE_TIME << p);
            q_win_row.push_back(r);
         end
      end
      mon_on = 1;

      @(negedge clk);
      rst = 1; en = 1;
      hold = $urandom_range(1000, 40000);
      k = 0;
      while (n_done == 0 && k < FRAME_CYC + 5000) begin
         @(negedge clk);
         k++;
         if (k == hold) en = 0;
      end
      check("frame_done_seen", n_done, 1);
      check("frame_length", t_done - t_first, FRAME_CYC);

      repeat (20) begin
         @(negedge clk);
         check("idle_oe_n", int'(oe_n), 1);
         check("idle_re_b", int'(re_b), 0);
      end
      check("frame_done_pulses", n_done, 1);
      check("frame_done_width", fd_cycles, 1);
      check("addr_queue_drained", q_addr.size(), 0);
      check("pixel_queue_drained", q_pix.size(), 0);
      check("window_queue_drained", q_win_len.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
